// File: rtl/i2c_master_sequencer.sv
// i2c_master_sequencer: single-master I2C transaction sequencer.
// Each transaction is START, an address sent LSB first, the R/W bit and an
// address acknowledge slot, then ByteCount data bytes with acknowledge slots,
// and finally STOP. Each bit slot has four quarter phases Q0..Q3, and each
// phase lasts CLKDIV clocks. SCL is low in Q0/Q1 and high in Q2/Q3.
// On this bus a sampled SdaIn=1 counts as an acknowledge.
//
// Ports:
//   Clk, Reset             system clock, synchronous active-high reset
//   Go                     command strobe (accepted only when idle)
//   Address, RorW          target address and direction, captured on Go
//   ByteCount              data bytes per transaction (0 is treated as 1)
//   WrData / WrNext        write byte and its one-cycle load strobe
//   RdData / RdValid       last received byte and its one-cycle update strobe
//   Busy, Done, Nack       status: in transaction, end pulse, sticky no-ack
//   SCL, SdaOut, SdaOe     bus clock and SDA drive (released when SdaOe=0)
//   SdaIn                  sampled SDA line
module i2c_master_sequencer #(
  parameter int ADDRESSLENGTH = 7,
  parameter int CLKDIV        = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Go,
  input  logic [ADDRESSLENGTH-1:0] Address,
  input  logic                     RorW,
  input  logic [3:0]               ByteCount,
  input  logic [7:0]               WrData,
  output logic                     WrNext,
  output logic [7:0]               RdData,
  output logic                     RdValid,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Nack,
  output logic                     SCL,
  output logic                     SdaOut,
  output logic                     SdaOe,
  input  logic                     SdaIn
);

  typedef enum logic [2:0] {IDLE, START, ADDR, RW, ADDRACK, DATA, DATAACK, STOP} state_t;

  localparam int BW = (ADDRESSLENGTH > 8) ? $clog2(ADDRESSLENGTH) : 3;

  state_t                   state, state_nx;
  logic [7:0]               qcnt;
  logic [2:0]               phase;
  logic [BW-1:0]            bitcnt;
  logic [3:0]               bytes_q;
  logic [ADDRESSLENGTH-1:0] addr_q;
  logic                     rw_q;
  logic [7:0]               shreg;
  logic                     ack_q;
  logic [7:0]               rddata_q;
  logic                     rdvalid_q;
  logic                     done_q;
  logic                     nack_q;
  logic                     tick, sample, slot_end, load;

  assign tick     = (qcnt == 8'(CLKDIV - 1));
  assign sample   = tick && (phase == 3'd2);
  assign slot_end = tick && (phase == 3'd3);
  // First clock of a write data byte: this cycle carries the WrNext strobe,
  // and the shifter takes WrData at the end of it.
  assign load     = (state == DATA) && !rw_q && (qcnt == '0) && (phase == '0) && (bitcnt == '0);

  assign RdData  = rddata_q;
  assign RdValid = rdvalid_q;
  assign Done    = done_q;
  assign Nack    = nack_q;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Go) state_nx = START;
      START:   if (tick && phase == 3'd1) state_nx = ADDR;
      ADDR:    if (slot_end && bitcnt == BW'(ADDRESSLENGTH - 1)) state_nx = RW;
      RW:      if (slot_end) state_nx = ADDRACK;
      ADDRACK: if (slot_end) state_nx = ack_q ? DATA : STOP;
      DATA:    if (slot_end && bitcnt == BW'(7)) state_nx = DATAACK;
      DATAACK: if (slot_end) begin
        if (!rw_q && !ack_q)    state_nx = STOP;
        else if (bytes_q == 4'd1) state_nx = STOP;
        else                      state_nx = DATA;
      end
      STOP:    if (tick && phase == 3'd5) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    SCL    = 1'b1;
    SdaOe  = 1'b0;
    SdaOut = 1'b1;
    WrNext = 1'b0;
    Busy   = (state != IDLE);
    case (state)
      IDLE:    ;
      START:   begin SdaOe = 1'b1; SdaOut = 1'b0; end
      ADDR:    begin SCL = phase[1]; SdaOe = 1'b1; SdaOut = addr_q[bitcnt]; end
      RW:      begin SCL = phase[1]; SdaOe = 1'b1; SdaOut = rw_q; end
      ADDRACK: SCL = phase[1];
      DATA: begin
        SCL = phase[1];
        if (!rw_q) begin
          SdaOe  = 1'b1;
          // The shifter is loaded only at the end of the load cycle, so bit 0
          // is taken straight from WrData to keep SDA steady from Q0 entry.
          SdaOut = load ? WrData[0] : shreg[0];
          WrNext = load;
        end
      end
      DATAACK: begin
        SCL = phase[1];
        if (rw_q) begin
          SdaOe  = 1'b1;
          SdaOut = (bytes_q != 4'd1);
        end
      end
      STOP: begin
        // Phases 0..3 are a slot with SDA low, and phases 4..5 hold SDA
        // released while SCL is high.
        SCL = (phase >= 3'd2);
        if (phase < 3'd4) begin
          SdaOe  = 1'b1;
          SdaOut = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      qcnt      <= '0;
      phase     <= '0;
      bitcnt    <= '0;
      bytes_q   <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      shreg     <= '0;
      ack_q     <= 1'b0;
      rddata_q  <= '0;
      rdvalid_q <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      rdvalid_q <= 1'b0;
      if (state == IDLE) begin
        qcnt   <= '0;
        phase  <= '0;
        bitcnt <= '0;
        if (Go) begin
          addr_q  <= Address;
          rw_q    <= RorW;
          bytes_q <= (ByteCount == '0) ? 4'd1 : ByteCount;
          nack_q  <= 1'b0;
        end
      end else begin
        qcnt <= tick ? '0 : qcnt + 8'd1;
        // State changes only happen on the last tick of a phase group, so
        // leaving a state always restarts the phase sequence.
        if (tick)
          phase <= ((state_nx != state) || (phase == 3'd3 && state != STOP)) ? '0 : phase + 3'd1;
        if (slot_end && (state == ADDR || state == DATA))
          bitcnt <= (state_nx != state) ? '0 : bitcnt + BW'(1);
        if (load)
          shreg <= WrData;
        else if (state == DATA && !rw_q && slot_end)
          shreg <= {1'b0, shreg[7:1]};
        if (state == DATA && rw_q && sample) begin
          shreg <= {SdaIn, shreg[7:1]};
          if (bitcnt == BW'(7)) begin
            rddata_q  <= {SdaIn, shreg[7:1]};
            rdvalid_q <= 1'b1;
          end
        end
        if (sample && (state == ADDRACK || state == DATAACK)) begin
          ack_q <= SdaIn;
          if (!SdaIn && (state == ADDRACK || !rw_q)) nack_q <= 1'b1;
        end
        if (slot_end && state == DATAACK) bytes_q <= bytes_q - 4'd1;
        if (tick && state == STOP && phase == 3'd5) done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Directed bench for i2c_master_sequencer. It uses an SCL-edge slave that
// returns SdaIn from a per-slot table, and a logger that records SDA at each
// rising edge of SCL.
module tb_i2c_master_sequencer;
  localparam int AL = 7;
  localparam int CD = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Go = 1'b0;
  logic [AL-1:0] Address = '0;
  logic          RorW = 1'b0;
  logic [3:0]    ByteCount = '0;
  logic [7:0]    WrData = '0;
  logic          WrNext;
  logic [7:0]    RdData;
  logic          RdValid, Busy, Done, Nack, SCL, SdaOut, SdaOe;
  logic          SdaIn = 1'b1;

  i2c_master_sequencer #(.ADDRESSLENGTH(AL), .CLKDIV(CD)) dut (
    .Clk(Clk), .Reset(Reset), .Go(Go), .Address(Address), .RorW(RorW),
    .ByteCount(ByteCount), .WrData(WrData), .WrNext(WrNext), .RdData(RdData),
    .RdValid(RdValid), .Busy(Busy), .Done(Done), .Nack(Nack), .SCL(SCL),
    .SdaOut(SdaOut), .SdaOe(SdaOe), .SdaIn(SdaIn)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor and slave state.
  int         slot = -1;
  int         rises = 0, wr_cnt = 0, rv_cnt = 0, done_cnt = 0, stop_cnt = 0;
  logic       out_log [0:63];
  logic       oe_log  [0:63];
  logic       in_tbl  [0:63];
  logic [7:0] rd_log  [0:15];
  logic [7:0] wbytes  [0:15];
  logic       scl_p = 1'b1, line_p = 1'b1, line_now;

  always @(negedge Clk) begin
    line_now = SdaOe ? SdaOut : 1'b1;
    if (scl_p && !SCL) begin
      slot++;
      if (slot >= 0 && slot < 64) SdaIn = in_tbl[slot];
    end
    if (!scl_p && SCL) begin
      rises++;
      if (slot >= 0 && slot < 64) begin
        out_log[slot] = SdaOut;
        oe_log[slot]  = SdaOe;
      end
    end
    if (scl_p && SCL && !line_p && line_now) stop_cnt++;
    if (WrNext) wr_cnt++;
    if (RdValid) begin
      if (rv_cnt < 16) rd_log[rv_cnt] = RdData;
      rv_cnt++;
    end
    if (Done) done_cnt++;
    scl_p  = SCL;
    line_p = line_now;
  end

  // WrData moves to the next byte only after the edge that consumes the current one.
  always @(posedge Clk) begin
    #1;
    WrData = wbytes[wr_cnt % 16];
  end

  task automatic clear_mon();
    slot = -1; rises = 0; wr_cnt = 0; rv_cnt = 0; done_cnt = 0; stop_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      in_tbl[i] = 1'b1; out_log[i] = 1'bx; oe_log[i] = 1'bx;
    end
  endtask

  task automatic go_txn(input logic [AL-1:0] a, input logic rw, input logic [3:0] n);
    @(negedge Clk);
    Address = a; RorW = rw; ByteCount = n; Go = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt == 0 && k < 3000) begin
      @(negedge Clk);
      k++;
    end
    repeat (3) @(negedge Clk);
    chk(tag, done_cnt, 1);
  endtask

  function automatic logic [7:0] pack8(input int base);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = out_log[base + i];
    return v;
  endfunction

  initial begin
    logic [7:0] rb [0:2];
    int k;
    for (int i = 0; i < 16; i++) wbytes[i] = '0;
    clear_mon();

    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_outs", {SCL, SdaOe, SdaOut, Busy, Done, Nack, WrNext, RdValid}, 8'b1010_0000);
    chk("rst_rddata", RdData, 8'h00);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // Two-byte write, all acknowledged
    clear_mon();
    wbytes[0] = 8'hA5; wbytes[1] = 8'h3C;
    go_txn(7'h2A, 1'b0, 4'd2);
    chk("wr_busy", Busy, 1);
    wait_done("wr_done");
    chk("wr_addr_bits", pack8(0), 8'h2A);
    chk("wr_byte0", pack8(9), 8'hA5);
    chk("wr_byte1", pack8(18), 8'h3C);
    chk("wr_ack_oe", {oe_log[26], oe_log[17], oe_log[8]}, 3'b000);
    chk("wr_wrnext", wr_cnt, 2);
    chk("wr_slots", rises - 1, 27);
    chk("wr_stop", stop_cnt, 1);
    chk("wr_nack", Nack, 0);
    chk("wr_idle", {Busy, SCL, SdaOe}, 3'b010);

    // Three-byte read
    clear_mon();
    rb[0] = 8'h11; rb[1] = 8'h22; rb[2] = 8'h33;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 8; i++) in_tbl[9 + 9*b + i] = rb[b][i];
    go_txn(7'h55, 1'b1, 4'd3);
    wait_done("rd_done");
    chk("rd_rw_bit", out_log[7], 1);
    chk("rd_count", rv_cnt, 3);
    chk("rd_byte0", rd_log[0], 8'h11);
    chk("rd_byte1", rd_log[1], 8'h22);
    chk("rd_byte2", rd_log[2], 8'h33);
    chk("rd_mack", {out_log[35], out_log[26], out_log[17]}, 3'b011);
    chk("rd_mack_oe", {oe_log[35], oe_log[26], oe_log[17]}, 3'b111);
    chk("rd_slots", rises - 1, 36);
    chk("rd_nack", Nack, 0);
    chk("rd_rddata", RdData, 8'h33);

    // Address not acknowledged
    clear_mon();
    in_tbl[8] = 1'b0;
    go_txn(7'h2A, 1'b0, 4'd2);
    wait_done("anak_done");
    chk("anak_nack", Nack, 1);
    chk("anak_wrnext", wr_cnt, 0);
    chk("anak_stop", stop_cnt, 1);
    chk("anak_slots", rises - 1, 9);

    // First of four write bytes not acknowledged; the new Go clears Nack
    clear_mon();
    in_tbl[17] = 1'b0;
    wbytes[0] = 8'h0F; wbytes[1] = 8'hF0;
    go_txn(7'h40, 1'b0, 4'd4);
    chk("dnak_nack_clr", Nack, 0);
    wait_done("dnak_done");
    chk("dnak_nack", Nack, 1);
    chk("dnak_wrnext", wr_cnt, 1);
    chk("dnak_stop", stop_cnt, 1);
    chk("dnak_slots", rises - 1, 18);

    // Reset during bit 4 of the first data byte
    clear_mon();
    wbytes[0] = 8'hA5; wbytes[1] = 8'h3C;
    go_txn(7'h2A, 1'b0, 4'd2);
    k = 0;
    while (slot < 13 && k < 2000) begin
      @(negedge Clk);
      k++;
    end
    chk("mid_reach_bit4", slot, 13);
    Reset = 1'b1;
    @(negedge Clk);
    chk("mid_rst_outs", {SCL, SdaOe, SdaOut, Busy, Nack, WrNext, RdValid}, 7'b1010000);
    Reset = 1'b0;
    repeat (40) @(negedge Clk);
    chk("mid_no_stop", stop_cnt, 0);
    chk("mid_no_done", done_cnt, 0);
    chk("mid_still_idle", {Busy, SCL}, 2'b01);

    // A normal transaction after that reset
    clear_mon();
    wbytes[0] = 8'h96;
    go_txn(7'h13, 1'b0, 4'd1);
    wait_done("post_done");
    chk("post_addr_bits", pack8(0), 8'h13);
    chk("post_byte0", pack8(9), 8'h96);
    chk("post_slots", rises - 1, 18);
    chk("post_wrnext", wr_cnt, 1);

    // Go while Busy is ignored
    clear_mon();
    wbytes[0] = 8'hC3;
    go_txn(7'h33, 1'b0, 4'd1);
    repeat (40) @(negedge Clk);
    Address = 7'h7F; RorW = 1'b1; ByteCount = 4'd5; Go = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
    chk("busy_go_busy", Busy, 1);
    wait_done("busy_go_done");
    chk("busy_go_addr", pack8(0), 8'h33);
    chk("busy_go_byte", pack8(9), 8'hC3);
    chk("busy_go_slots", rises - 1, 18);
    repeat (20) @(negedge Clk);
    chk("busy_go_idle", Busy, 0);

    // Go together with Reset
    clear_mon();
    Address = 7'h2A; RorW = 1'b0; ByteCount = 4'd1; Go = 1'b1; Reset = 1'b1;
    @(negedge Clk);
    Go = 1'b0; Reset = 1'b0;
    chk("gorst_busy", Busy, 0);
    repeat (30) @(negedge Clk);
    chk("gorst_idle", {Busy, SCL, SdaOe}, 3'b010);
    chk("gorst_rises", rises, 0);

    // ByteCount of 0 behaves like 1
    clear_mon();
    wbytes[0] = 8'h5A;
    go_txn(7'h01, 1'b0, 4'd0);
    wait_done("bc0_done");
    chk("bc0_wrnext", wr_cnt, 1);
    chk("bc0_byte0", pack8(9), 8'h5A);
    chk("bc0_slots", rises - 1, 18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
